// File: rtl/prog_loader_pkg.sv
// Shared constants for the program loader and the program ROM.
// Holds the default operator/operand width, the writable ROM depth, the
// assembled word width and the loader FSM state encoding.
package prog_loader_pkg;

    localparam int unsigned DATA_WIDTH     = 16;
    localparam int unsigned ROM_DEPTH      = 16;
    localparam int unsigned WORD_WIDTH     = 32;
    localparam int unsigned BYTES_PER_WORD = WORD_WIDTH / 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRecv  = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/prog_word_assembler.sv
// Big-endian byte-to-word assembler: the first accepted byte of a word lands
// in bits 31:24 and the fourth in bits 7:0.
//   clk, rst_n     clock, asynchronous active-low reset
//   clear_i        synchronous clear of byte index and shift register
//   byte_valid_i   a byte is accepted this cycle
//   byte_i         byte being accepted
//   word_o         word including the byte accepted this cycle
//   word_last_o    the byte accepted this cycle completes a word
module prog_word_assembler
    import prog_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  word_last_o
);

    logic [1:0]            idx_q, idx_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;

    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        if (clear_i) begin
            idx_d   = '0;
            shift_d = '0;
        end else if (byte_valid_i) begin
            // Index wraps to 0 after the fourth byte, ready for the next word.
            idx_d   = idx_q + 2'd1;
            shift_d = {shift_q[WORD_WIDTH-9:0], byte_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Combinational view so the loader can capture the full word on the
    // same edge that accepts the last byte.
    assign word_o      = {shift_q[WORD_WIDTH-9:0], byte_i};
    assign word_last_o = byte_valid_i && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a byte stream, assembles 32-bit program words and
// writes them to consecutive program-memory addresses.
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, word_count          load request and number of words (sampled in idle)
//   in_data, in_valid/in_ready byte stream handshake
//   wr_en, wr_addr             one-cycle write strobe and address
//   wr_operator, wr_operand    upper / lower half of the written word
//   busy, done, overflow       status; overflow is sticky until the next start
module prog_loader #(
    parameter int unsigned DATA_WIDTH = prog_loader_pkg::DATA_WIDTH,
    parameter int unsigned ROM_DEPTH  = prog_loader_pkg::ROM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           word_count,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [15:0]           wr_addr,
    output logic [DATA_WIDTH-1:0] wr_operator,
    output logic [DATA_WIDTH-1:0] wr_operand,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    import prog_loader_pkg::*;

    localparam logic [15:0] LastAddr = 16'(ROM_DEPTH - 1);

    state_e                state_q, state_d;
    logic [15:0]           addr_q, addr_d;
    logic [15:0]           remain_q, remain_d;
    logic                  ovf_q, ovf_d;
    logic [15:0]           wr_addr_q, wr_addr_d;
    logic [WORD_WIDTH-1:0] wr_word_q, wr_word_d;

    logic                  asm_clear;
    logic                  byte_xfer;
    logic [WORD_WIDTH-1:0] asm_word;
    logic                  asm_last;

    assign byte_xfer = in_valid && in_ready;

    prog_word_assembler u_assembler (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (asm_clear),
        .byte_valid_i (byte_xfer),
        .byte_i       (in_data),
        .word_o       (asm_word),
        .word_last_o  (asm_last)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        ovf_d     = ovf_q;
        wr_addr_d = wr_addr_q;
        wr_word_d = wr_word_q;
        asm_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ovf_d     = 1'b0;
                    asm_clear = 1'b1;
                    if (word_count == 16'd0) begin
                        state_d = StDone;
                    end else begin
                        addr_d   = '0;
                        remain_d = word_count;
                        state_d  = StRecv;
                    end
                end
            end
            StRecv: begin
                // Write outputs are registered here so they hold between writes.
                if (asm_last) begin
                    wr_addr_d = addr_q;
                    wr_word_d = asm_word;
                    state_d   = StWrite;
                end
            end
            StWrite: begin
                addr_d   = addr_q + 16'd1;
                remain_d = remain_q - 16'd1;
                if (remain_q == 16'd1) begin
                    state_d = StDone;
                end else if (addr_q == LastAddr) begin
                    ovf_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StRecv;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            remain_q  <= '0;
            ovf_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_word_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            ovf_q     <= ovf_d;
            wr_addr_q <= wr_addr_d;
            wr_word_q <= wr_word_d;
        end
    end

    assign in_ready    = (state_q == StRecv);
    assign wr_en       = (state_q == StWrite);
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign overflow    = ovf_q;
    assign wr_addr     = wr_addr_q;
    assign wr_operator = wr_word_q[WORD_WIDTH-1 -: DATA_WIDTH];
    assign wr_operand  = wr_word_q[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus randomized
// loads checked against a word-list reference model.
module tb_prog_loader;

    localparam int unsigned RomDepth = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] word_count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_operator;
    logic [15:0] wr_operand;
    logic        busy;
    logic        done;
    logic        overflow;

    always #5 clk = ~clk;

    prog_loader #(
        .DATA_WIDTH (16),
        .ROM_DEPTH  (RomDepth)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .word_count  (word_count),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_operator (wr_operator),
        .wr_operand  (wr_operand),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] stream[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " in_ready"}, 32'(in_ready), 0);
        chk({tag, " wr_en"}, 32'(wr_en), 0);
        chk({tag, " wr_addr"}, 32'(wr_addr), 0);
        chk({tag, " wr_operator"}, 32'(wr_operator), 0);
        chk({tag, " wr_operand"}, 32'(wr_operand), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " overflow"}, 32'(overflow), 0);
    endtask

    // Runs one load of 'wc' words from 'stream'. Expected writes come from the
    // word list: min(wc, RomDepth) words, big-endian, at addresses 0,1,2,...
    task automatic run_load(input string tag, input int wc, input int gap_pct,
                            input int stall_at, input int stall_len, input int poke_at,
                            output int done_cyc);
        int          nw;
        bit          exp_ovf;
        logic [15:0] e_addr[$];
        logic [31:0] e_word[$];
        logic [31:0] ew;
        int          bi      = 0;
        int          cyc     = 0;
        int          last_x  = -100;
        int          stalled = 0;
        int          nwr     = 0;
        bit          got_done = 0;

        nw      = (wc > int'(RomDepth)) ? int'(RomDepth) : wc;
        exp_ovf = (wc > int'(RomDepth));
        for (int w = 0; w < nw; w++) begin
            e_addr.push_back(16'(w));
            e_word.push_back({stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]});
        end

        start      = 1'b1;
        word_count = 16'(wc);
        in_valid   = 1'b0;
        tick();
        start = 1'b0;

        while (cyc < 2000) begin
            if (wr_en === 1'b1) begin
                nwr++;
                chk({tag, " in_ready during write"}, 32'(in_ready), 0);
                if (e_addr.size() == 0) begin
                    chk({tag, " write count"}, nwr, nw);
                end else begin
                    ew = e_word.pop_front();
                    chk({tag, " wr_addr"}, 32'(wr_addr), 32'(e_addr.pop_front()));
                    chk({tag, " wr_operator"}, 32'(wr_operator), 32'(ew[31:16]));
                    chk({tag, " wr_operand"}, 32'(wr_operand), 32'(ew[15:0]));
                end
            end
            if (wc == 0) chk({tag, " in_ready idle load"}, 32'(in_ready), 0);
            if (done === 1'b1) begin
                got_done = 1;
                break;
            end
            start      = (cyc == poke_at);
            word_count = (cyc == poke_at) ? 16'd3 : 16'(wc);
            if (stalled < stall_len && bi == stall_at && in_ready === 1'b1) begin
                in_valid = 1'b0;
                stalled++;
            end else if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = (bi < stream.size());
            end
            in_data = (in_valid && bi < stream.size()) ? stream[bi] : 8'($urandom);
            if (in_valid && in_ready === 1'b1) begin
                bi++;
                last_x = cyc;
            end
            tick();
            cyc++;
        end
        start = 1'b0;

        chk({tag, " done seen"}, 32'(got_done), 1);
        chk({tag, " write count"}, nwr, nw);
        chk({tag, " overflow at done"}, 32'(overflow), 32'(exp_ovf));
        chk({tag, " busy at done"}, 32'(busy), 1);
        if (wc > 0) chk({tag, " done latency"}, cyc - last_x, 2);
        else        chk({tag, " done after start"}, cyc, 0);
        done_cyc = cyc;

        // Keep offering data: nothing may be accepted once the load is over.
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk({tag, " done cleared"}, 32'(done), 0);
            chk({tag, " idle busy"}, 32'(busy), 0);
            chk({tag, " idle in_ready"}, 32'(in_ready), 0);
            chk({tag, " idle wr_en"}, 32'(wr_en), 0);
            chk({tag, " overflow sticky"}, 32'(overflow), 32'(exp_ovf));
        end
        in_valid = 1'b0;
    endtask

    task automatic fill_random(input int nbytes);
        stream.delete();
        for (int i = 0; i < nbytes; i++) stream.push_back(8'($urandom));
    endtask

    initial begin
        int d0;
        int d1;
        int wc;
        logic [15:0] hold_addr;

        rst_n      = 1'b0;
        start      = 1'b0;
        word_count = '0;
        in_data    = '0;
        in_valid   = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Two-word load, valid held high.
        stream = '{8'h30, 8'h01, 8'h00, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44};
        run_load("two_word", 2, 0, -1, 0, -1, d0);
        chk("hold wr_addr", 32'(wr_addr), 1);
        chk("hold wr_operator", 32'(wr_operator), 32'h1122);
        chk("hold wr_operand", 32'(wr_operand), 32'h3344);

        // Same stream stalled for 3 cycles between bytes 2 and 3.
        run_load("stall", 2, 0, 2, 3, -1, d1);
        chk("stall adds 3 cycles", d1 - d0, 3);

        // Zero-length load.
        run_load("zero", 0, 0, -1, 0, -1, d0);

        // Overflow: 17 words into a 16-word ROM.
        fill_random(68);
        run_load("overflow", 17, 0, -1, 0, -1, d0);

        // Start pulse in mid-load must be ignored; also clears sticky overflow.
        fill_random(16);
        run_load("start_ignored", 4, 0, -1, 0, 3, d0);

        // Reset after two bytes of a word, then a fresh one-word load.
        hold_addr = wr_addr;
        chk("pre-reset wr_addr", 32'(hold_addr), 3);
        start      = 1'b1;
        word_count = 16'd1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick();
        in_data = 8'hBB;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        tick();
        rst_n = 1'b1;
        tick();
        stream = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load("after_reset", 1, 0, -1, 0, -1, d0);

        // Randomized loads with random valid gaps.
        for (int r = 0; r < 5; r++) begin
            wc = int'($urandom_range(6, 1));
            fill_random(4 * wc);
            run_load("random", wc, 30, -1, 0, -1, d0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the operator half and the operand half of a program word.
REQ-002 Parameter ROM_DEPTH, default 16: number of program-memory words that may be written (addresses 0..ROM_DEPTH-1).
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  single-cycle request to begin a load.
REQ-006 Port word_count  input  16  number of words to load; sampled only on an accepted start.
REQ-007 Port in_data  input  8  program byte stream.
REQ-008 Port in_valid  input  1  in_data is valid.
REQ-009 Port in_ready  output  1  loader accepts a byte this cycle.
REQ-010 Port wr_en  output  1  program-memory write strobe.
REQ-011 Port wr_addr  output  16  write address.
REQ-012 Port wr_operator  output  DATA_WIDTH  upper half of the word (bits 31:16).
REQ-013 Port wr_operand  output  DATA_WIDTH  lower half of the word (bits 15:0).
REQ-014 Port busy, done, overflow  output  1 each  status.

Function
REQ-015 The FSM SHALL have four states: IDLE, RECV, WRITE and DONE.
REQ-016 In IDLE, start=1 with word_count>0 SHALL clear the address and byte counters, latch word_count, clear overflow, and enter RECV.
REQ-017 In IDLE, start=1 with word_count=0 SHALL enter DONE directly, with no write.
REQ-018 A start pulse outside IDLE SHALL be ignored.
REQ-019 in_ready SHALL be 1 only in RECV; a byte transfers on a cycle where in_valid=1 and in_ready=1.
REQ-020 Bytes SHALL be assembled big-endian: the 1st byte goes to bits 31:24 and the 4th byte to bits 7:0.
REQ-021 The cycle after the 4th byte is accepted, the FSM SHALL be in WRITE, with wr_en=1 for exactly one cycle and wr_addr, wr_operator and wr_operand holding the assembled word; in_ready SHALL be 0 in that cycle.
REQ-022 On leaving WRITE, the address SHALL increment and the remaining count SHALL decrement.
- If remaining reaches 0, the FSM SHALL go to DONE.
- Otherwise, if the new address equals ROM_DEPTH, overflow SHALL be set and the FSM SHALL go to DONE.
- Otherwise the FSM SHALL return to RECV.
REQ-023 DONE SHALL last one cycle, with done=1 in that cycle, then return to IDLE; latency from the last accepted byte to done is 2 cycles.
REQ-024 busy SHALL be 1 in RECV, WRITE and DONE, and 0 in IDLE.
REQ-025 overflow SHALL be sticky until the next accepted start.
REQ-026 in_valid with no transfer (in_ready=0) SHALL have no effect; gaps in in_valid during RECV SHALL only stall assembly.
REQ-027 The address SHALL never exceed ROM_DEPTH-1 while wr_en=1.
REQ-028 wr_addr, wr_operator and wr_operand SHALL hold their last values when wr_en=0.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE and zero every output, address, counter and assembly register, including during RECV or WRITE.
REQ-030 No partial word captured before reset SHALL ever be written after reset.

Structure
REQ-031 DATA_WIDTH, ROM_DEPTH, the 32-bit word width and the FSM state encodings SHALL live in a shared constants include used by both the loader and the program ROM.
REQ-032 Byte-to-word assembly (2-bit byte index plus 32-bit shift register) SHALL be a sub-module named prog_word_assembler; the FSM, counters and status logic SHALL stay in prog_loader.

Verification
REQ-033 start, word_count=2, bytes 30 01 00 05 11 22 33 44 with in_valid held high -> one write addr 0 operator 0x3001 operand 0x0005, one write addr 1 operator 0x1122 operand 0x3344, done 2 cycles after the 8th byte, overflow=0.
REQ-034 Same stream as REQ-033 with in_valid dropped for 3 cycles between bytes 2 and 3 -> identical writes; stall adds exactly 3 cycles.
REQ-035 word_count=0 -> done pulse the cycle after start, no wr_en, in_ready never 1.
REQ-036 word_count=17 with ROM_DEPTH=16 -> 16 writes to addr 0..15, then overflow=1 and done; in_ready stays 0 afterwards.
REQ-037 rst_n low after 2 bytes of a word, then a new load of 1 word -> no write from the partial word; the new word is written to addr 0.
REQ-038 start pulsed during RECV -> ignored; load completes with the original word_count.
